// File: rtl/hw_accel_dpram_pkg.sv
// Shared types and helpers for the accelerator byte-enable dual-port RAM.
// Byte parity storage is enabled by the HW_ACCEL_DPRAM_PARITY_EN macro.
package hw_accel_dpram_pkg;

  typedef enum logic [0:0] {
    SEQ_CLEAR = 1'b0,
    SEQ_READY = 1'b1
  } seq_state_e;

  localparam logic [1:0] WM_WRITE_FIRST = 2'd0;
  localparam logic [1:0] WM_READ_FIRST  = 2'd1;
  localparam logic [1:0] WM_NO_CHANGE   = 2'd2;

  // Widest byte the parity helper accepts; narrower bytes are zero-padded.
  localparam int PAR_MAX_W = 64;

  function automatic int num_bytes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  function automatic logic byte_parity(input logic [PAR_MAX_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/hw_accel_dpram_out_stage.sv
// Per-port read pipeline: array read register, optional output register,
// and valid/parity-error alignment. dout only changes on an issued read.
module hw_accel_dpram_out_stage #(
  parameter int DATA_WIDTH = 32,
  parameter bit OUT_REG    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_issue,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_perr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  parity_err
);

  logic [DATA_WIDTH-1:0] s1_data_r;
  logic                  s1_valid_r;
  logic                  s1_perr_r;

  // first stage: capture the word read from the array
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_r  <= '0;
      s1_valid_r <= 1'b0;
      s1_perr_r  <= 1'b0;
    end else begin
      s1_valid_r <= rd_issue;
      s1_perr_r  <= rd_issue & rd_perr;
      if (rd_issue) begin
        s1_data_r <= rd_data;
      end
    end
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic [DATA_WIDTH-1:0] s2_data_r;
      logic                  s2_valid_r;
      logic                  s2_perr_r;

      // optional second stage, keeps parity error aligned with valid
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_data_r  <= '0;
          s2_valid_r <= 1'b0;
          s2_perr_r  <= 1'b0;
        end else begin
          s2_valid_r <= s1_valid_r;
          s2_perr_r  <= s1_perr_r;
          if (s1_valid_r) begin
            s2_data_r <= s1_data_r;
          end
        end
      end

      assign dout       = s2_data_r;
      assign dout_valid = s2_valid_r;
      assign parity_err = s2_perr_r;
    end else begin : g_noreg
      assign dout       = s1_data_r;
      assign dout_valid = s1_valid_r;
      assign parity_err = s1_perr_r;
    end
  endgenerate

endmodule

// File: rtl/hw_accel_dp_ram_be.sv
// Single-clock true dual-port RAM with byte enables, clear-after-reset
// sequencer and same-address collision handling (parity: HW_ACCEL_DPRAM_PARITY_EN).
module hw_accel_dp_ram_be
  import hw_accel_dpram_pkg::*;
#(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 10,
  parameter int    BYTE_WIDTH     = 8,
  parameter string WRITE_MODE_A   = "READ_FIRST",
  parameter string WRITE_MODE_B   = "READ_FIRST",
  parameter string OUTPUT_REG_A   = "FALSE",
  parameter string OUTPUT_REG_B   = "FALSE",
  parameter string CLEAR_ON_RESET = "TRUE",
  parameter string RAM_INIT_FILE  = ""
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             a_req,
  input  logic                             a_we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]            a_addr,
  input  logic [DATA_WIDTH-1:0]            a_din,
  output logic [DATA_WIDTH-1:0]            a_dout,
  output logic                             a_dout_valid,
  output logic                             a_parity_err,
  input  logic                             b_req,
  input  logic                             b_we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]            b_addr,
  input  logic [DATA_WIDTH-1:0]            b_din,
  output logic [DATA_WIDTH-1:0]            b_dout,
  output logic                             b_dout_valid,
  output logic                             b_parity_err,
  output logic                             init_busy,
  output logic                             collision
);

  localparam int NB    = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [1:0] MODE_A = (WRITE_MODE_A == "WRITE_FIRST") ? WM_WRITE_FIRST :
                                  (WRITE_MODE_A == "NO_CHANGE")   ? WM_NO_CHANGE : WM_READ_FIRST;
  localparam logic [1:0] MODE_B = (WRITE_MODE_B == "WRITE_FIRST") ? WM_WRITE_FIRST :
                                  (WRITE_MODE_B == "NO_CHANGE")   ? WM_NO_CHANGE : WM_READ_FIRST;
  localparam bit OREG_A = (OUTPUT_REG_A == "TRUE");
  localparam bit OREG_B = (OUTPUT_REG_B == "TRUE");
  localparam bit CLR_EN = (CLEAR_ON_RESET == "TRUE");

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  seq_state_e            state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0] clr_addr_r, clr_addr_nxt_s;
  logic                  init_busy_r;
  logic                  collision_r;

  logic                  a_acc_s, b_acc_s, a_wr_s, b_wr_s, same_s, clr_we_s;
  logic [DATA_WIDTH-1:0] a_old_s, b_old_s, a_merge_s, b_merge_s, a_rdata_s, b_rdata_s;
  logic [NB-1:0]         b_win_s;
  logic                  a_issue_s, b_issue_s, a_perr_s, b_perr_s;

  // sequencer next state: walk the clear address up to the top word, then go READY
  always_comb begin
    state_nxt_s    = state_r;
    clr_addr_nxt_s = clr_addr_r;
    case (state_r)
      SEQ_CLEAR: begin
        clr_addr_nxt_s = clr_addr_r + ADDR_WIDTH'(1);
        if (clr_addr_r == LAST_ADDR) begin
          state_nxt_s = SEQ_READY;
        end else begin
          state_nxt_s = SEQ_CLEAR;
        end
      end
      SEQ_READY: state_nxt_s = SEQ_READY;
      default:   state_nxt_s = SEQ_CLEAR;
    endcase
  end

  // sequencer state register; rst restarts the clear at address 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= CLR_EN ? SEQ_CLEAR : SEQ_READY;
      clr_addr_r  <= '0;
      init_busy_r <= CLR_EN;
    end else begin
      state_r     <= state_nxt_s;
      clr_addr_r  <= clr_addr_nxt_s;
      init_busy_r <= (state_nxt_s == SEQ_CLEAR);
    end
  end

  assign clr_we_s = (state_r == SEQ_CLEAR) & ~rst;
  assign a_acc_s  = a_req & ~rst & (state_r == SEQ_READY);
  assign b_acc_s  = b_req & ~rst & (state_r == SEQ_READY);
  assign a_wr_s   = a_acc_s & a_we;
  assign b_wr_s   = b_acc_s & b_we;
  assign same_s   = (a_addr == b_addr);
  assign a_old_s  = mem_r[a_addr];
  assign b_old_s  = mem_r[b_addr];

  // per-port merged words; B loses the bytes A also writes on a shared address
  always_comb begin
    a_merge_s = a_old_s;
    b_merge_s = b_old_s;
    b_win_s   = b_be;
    for (int i = 0; i < NB; i++) begin
      if (a_be[i]) begin
        a_merge_s[i*BYTE_WIDTH +: BYTE_WIDTH] = a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        a_merge_s[i*BYTE_WIDTH +: BYTE_WIDTH] = a_old_s[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (b_be[i]) begin
        b_merge_s[i*BYTE_WIDTH +: BYTE_WIDTH] = b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        b_merge_s[i*BYTE_WIDTH +: BYTE_WIDTH] = b_old_s[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (same_s && a_wr_s && a_be[i]) begin
        b_win_s[i] = 1'b0;
      end else begin
        b_win_s[i] = b_be[i];
      end
    end
  end

`ifdef HW_ACCEL_DPRAM_PARITY_EN
  logic [NB-1:0] par_r [DEPTH];
  logic [NB-1:0] a_din_par_s, b_din_par_s;

  function automatic logic [NB-1:0] word_parity(input logic [DATA_WIDTH-1:0] w);
    logic [NB-1:0]        r;
    logic [PAR_MAX_W-1:0] pad;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      pad                 = '0;
      pad[BYTE_WIDTH-1:0] = w[i*BYTE_WIDTH +: BYTE_WIDTH];
      r[i]                = byte_parity(pad);
    end
    return r;
  endfunction

  assign a_din_par_s = word_parity(a_din);
  assign b_din_par_s = word_parity(b_din);
  // bytes being overwritten by a write-first port are not reported
  assign a_perr_s = |((par_r[a_addr] ^ word_parity(a_old_s)) &
                      ~((a_we && MODE_A == WM_WRITE_FIRST) ? a_be : {NB{1'b0}}));
  assign b_perr_s = |((par_r[b_addr] ^ word_parity(b_old_s)) &
                      ~((b_we && MODE_B == WM_WRITE_FIRST) ? b_be : {NB{1'b0}}));
`else
  assign a_perr_s = 1'b0;
  assign b_perr_s = 1'b0;
`endif

  // array writes: clearing owns the array; otherwise both ports write per enabled byte
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[clr_addr_r] <= '0;
`ifdef HW_ACCEL_DPRAM_PARITY_EN
      par_r[clr_addr_r] <= '0;
`endif
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (a_wr_s && a_be[i]) begin
          mem_r[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef HW_ACCEL_DPRAM_PARITY_EN
          par_r[a_addr][i] <= a_din_par_s[i];
`endif
        end
        if (b_wr_s && b_win_s[i]) begin
          mem_r[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef HW_ACCEL_DPRAM_PARITY_EN
          par_r[b_addr][i] <= b_din_par_s[i];
`endif
        end
      end
    end
  end

  assign a_issue_s = a_acc_s & (~a_we | (MODE_A != WM_NO_CHANGE));
  assign b_issue_s = b_acc_s & (~b_we | (MODE_B != WM_NO_CHANGE));
  assign a_rdata_s = (a_we && MODE_A == WM_WRITE_FIRST) ? a_merge_s : a_old_s;
  assign b_rdata_s = (b_we && MODE_B == WM_WRITE_FIRST) ? b_merge_s : b_old_s;

  // collision flag, one cycle after both ports hit the same word
  always_ff @(posedge clk) begin
    if (rst) begin
      collision_r <= 1'b0;
    end else begin
      collision_r <= a_acc_s & b_acc_s & same_s;
    end
  end

  assign init_busy = init_busy_r;
  assign collision = collision_r;

  hw_accel_dpram_out_stage #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OREG_A)) u_out_a (
    .clk        (clk),
    .rst        (rst),
    .rd_issue   (a_issue_s),
    .rd_data    (a_rdata_s),
    .rd_perr    (a_perr_s),
    .dout       (a_dout),
    .dout_valid (a_dout_valid),
    .parity_err (a_parity_err)
  );

  hw_accel_dpram_out_stage #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OREG_B)) u_out_b (
    .clk        (clk),
    .rst        (rst),
    .rd_issue   (b_issue_s),
    .rd_data    (b_rdata_s),
    .rd_perr    (b_perr_s),
    .dout       (b_dout),
    .dout_valid (b_dout_valid),
    .parity_err (b_parity_err)
  );

endmodule

// File: tb/tb_hw_accel_dp_ram_be.sv
// Scoreboard bench: two instances (A WRITE_FIRST/B READ_FIRST, and
// A NO_CHANGE/B READ_FIRST with registered B output) share one stimulus stream.
module tb_hw_accel_dp_ram_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_be, b_be, a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic [31:0] d0a, d0b, d1a, d1b;
  logic        v0a, v0b, v1a, v1b, p0a, p0b, p1a, p1b;
  logic        busy0, busy1, col0, col1;

  hw_accel_dp_ram_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST"),
    .OUTPUT_REG_A("FALSE"), .OUTPUT_REG_B("FALSE"),
    .CLEAR_ON_RESET("TRUE"), .RAM_INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(d0a), .a_dout_valid(v0a), .a_parity_err(p0a),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(d0b), .b_dout_valid(v0b), .b_parity_err(p0b),
    .init_busy(busy0), .collision(col0)
  );

  hw_accel_dp_ram_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST"),
    .OUTPUT_REG_A("FALSE"), .OUTPUT_REG_B("TRUE"),
    .CLEAR_ON_RESET("TRUE"), .RAM_INIT_FILE("")
  ) dut2 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(d1a), .a_dout_valid(v1a), .a_parity_err(p1a),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(d1b), .b_dout_valid(v1b), .b_parity_err(p1b),
    .init_busy(busy1), .collision(col1)
  );

  typedef struct {
    logic [31:0] d;
    logic        p;
    int          c;
  } exp_t;

  exp_t  q [4][$];
  int    col_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  logic  inj_perr = 1'b0;

  logic        mv [4];
  logic [31:0] md [4];
  logic        mp [4];
  string       nm [4] = '{"dutA", "dutB", "dut2A", "dut2B"};

  assign mv[0] = v0a; assign md[0] = d0a; assign mp[0] = p0a;
  assign mv[1] = v0b; assign md[1] = d0b; assign mp[1] = p0b;
  assign mv[2] = v1a; assign md[2] = d1a; assign mp[2] = p1a;
  assign mv[3] = v1b; assign md[3] = d1b; assign mp[3] = p1b;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pop and compare whenever a port presents valid data or a collision pulse
  always @(negedge clk) begin
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      if (mv[p] === 1'b1) begin
        checks++;
        if (q[p].size() == 0) begin
          failures++;
          $display("FAIL %s_unexpected_valid: dout=%h at cyc %0d, required no valid", nm[p], md[p], cyc);
        end else begin
          e = q[p].pop_front();
          if (md[p] !== e.d || mp[p] !== e.p || cyc != e.c) begin
            failures++;
            $display("FAIL %s_read: dout=%h perr=%b cyc=%0d, required dout=%h perr=%b cyc=%0d",
                     nm[p], md[p], mp[p], cyc, e.d, e.p, e.c);
          end
        end
      end
    end
    if (col0 === 1'b1) begin
      checks++;
      if (col_q.size() == 0) begin
        failures++;
        $display("FAIL collision_unexpected: pulse at cyc %0d, required none", cyc);
      end else begin
        int ec;
        ec = col_q.pop_front();
        if (ec != cyc) begin
          failures++;
          $display("FAIL collision_cycle: pulse at cyc %0d, required cyc %0d", cyc, ec);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // one cycle of stimulus on both ports plus the hand-computed responses
  task automatic op(input logic ar, input logic aw, input logic [3:0] abe, input logic [3:0] aad,
                    input logic [31:0] ad, input logic br, input logic bw, input logic [3:0] bbe,
                    input logic [3:0] bad, input logic [31:0] bd, input logic [31:0] ea,
                    input logic [31:0] eb, input logic ecol);
    a_req = ar; a_we = aw; a_be = abe; a_addr = aad; a_din = ad;
    b_req = br; b_we = bw; b_be = bbe; b_addr = bad; b_din = bd;
    if (ar) begin
      q[0].push_back('{ea, inj_perr, cyc + 1});
      if (!aw) q[2].push_back('{ea, inj_perr, cyc + 1});
    end
    if (br) begin
      q[1].push_back('{eb, 1'b0, cyc + 1});
      q[3].push_back('{eb, 1'b0, cyc + 2});
    end
    if (ecol) col_q.push_back(cyc + 1);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic idle(input int n);
    a_req = 1'b0; b_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // count init_busy cycles, optionally firing requests that must be dropped
  task automatic wait_clear(input string name, input bit junk);
    int cnt;
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 100) begin
      if (junk) begin
        a_req = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 4'd1; a_din = 32'hDEADBEEF;
        b_req = 1'b1; b_we = 1'b0; b_be = 4'h0; b_addr = 4'd1; b_din = 32'h0;
      end
      cnt++;
      @(negedge clk);
    end
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0;
    chk(name, 32'(cnt), 32'd16);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 4'h0; a_din = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 4'h0; b_din = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_dout", d0a, 32'h0);
    chk("rst_a_valid", {31'h0, v0a}, 32'h0);
    chk("rst_b_valid2", {31'h0, v1b}, 32'h0);
    chk("rst_perr", {30'h0, p0a, p0b}, 32'h0);
    chk("rst_collision", {31'h0, col0}, 32'h0);
    chk("rst_init_busy", {31'h0, busy0}, 32'h1);
    rst = 1'b0;
    wait_clear("clear_len_first", 1'b1);
    chk("busy_dut2_done", {31'h0, busy1}, 32'h0);

    // pre-fill, then reset and confirm the clear wipes everything
    for (int i = 0; i < 16; i++) begin
      w = 32'hA5000000 + 32'(i);
      op(1'b1, 1'b1, 4'hF, 4'(i), w, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, w, 32'h0, 1'b0);
    end
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear("clear_len_refill", 1'b0);
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 1'b0, 4'h0, 4'(i), 32'h0, 1'b1, 1'b0, 4'h0, 4'(15 - i), 32'h0,
         32'h0, 32'h0, 1'b0);
    end

    // byte-enable merge and no-op write
    op(1'b1, 1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'hAABBCCDD, 32'h0, 1'b0);
    op(1'b1, 1'b1, 4'h5, 4'd5, 32'h11223344, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'hAA22CC44, 32'h0, 1'b0);
    op(1'b1, 1'b1, 4'h0, 4'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'hAA22CC44, 32'h0, 1'b0);
    op(1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 32'hAA22CC44, 32'hAA22CC44, 1'b1);

    // write/write collision: A owns bytes 1:0, B's exclusive bytes 3:2 land too
    op(1'b1, 1'b1, 4'h3, 4'd3, 32'hFFFFFFFF, 1'b1, 1'b1, 4'hF, 4'd3, 32'h12345678,
       32'h0000FFFF, 32'h00000000, 1'b1);
    op(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 32'h0, 32'h1234FFFF, 1'b0);

    // write-first A vs read-first B on the same word
    op(1'b1, 1'b1, 4'hF, 4'd7, 32'hCAFE0001, 1'b1, 1'b0, 4'h0, 4'd7, 32'h0,
       32'hCAFE0001, 32'h00000000, 1'b1);
    op(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 32'hCAFE0001, 32'hCAFE0001, 1'b1);
    op(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b1, 1'b1, 4'hC, 4'd7, 32'h0BADF00D,
       32'hCAFE0001, 32'hCAFE0001, 1'b1);
    op(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'h0BAD0001, 32'h0, 1'b0);
    op(1'b1, 1'b1, 4'hF, 4'd12, 32'h77777777, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'h77777777, 32'h0, 1'b0);
    idle(3);

    // reset partway through the clear restarts the full sweep
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_mid_clear", {31'h0, busy0}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear("clear_len_restart", 1'b0);
    op(1'b1, 1'b0, 4'h0, 4'd12, 32'h0, 1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 32'h0, 32'h0, 1'b0);

`ifdef HW_ACCEL_DPRAM_PARITY_EN
    op(1'b1, 1'b1, 4'hF, 4'd2, 32'h00000055, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'h00000055, 32'h0, 1'b0);
    idle(1);
    dut.mem_r[2]  = dut.mem_r[2] ^ 32'h1;
    dut2.mem_r[2] = dut2.mem_r[2] ^ 32'h1;
    inj_perr = 1'b1;
    op(1'b1, 1'b0, 4'h0, 4'd2, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'h00000054, 32'h0, 1'b0);
    inj_perr = 1'b0;
`endif

    idle(4);
    for (int p = 0; p < 4; p++) begin
      chk({nm[p], "_pending"}, 32'(q[p].size()), 32'd0);
    end
    chk("collision_pending", 32'(col_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
